// File: rtl/gray_sobel_pkg.sv
// Shared types and constants for the grayscale/Sobel tile: pixel width,
// frame sequencer states and default frame geometry.
package gray_sobel_pkg;

  localparam int PIXEL_WIDTH = 8;
  localparam int IMG_W_DEF   = 16;
  localparam int IMG_H_DEF   = 16;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    DRAIN  = 2'd2,
    DONE   = 2'd3
  } frame_state_t;

endpackage

// File: rtl/raster_counter.sv
// Raster position counter: col advances on each step and wraps into row;
// last_o flags the bottom-right pixel of the frame.
module raster_counter
  import gray_sobel_pkg::*;
#(
  parameter int W = IMG_W_DEF,
  parameter int H = IMG_H_DEF
) (
  input  logic                 clk_i,
  input  logic                 nreset_i,
  input  logic                 clear_i,
  input  logic                 advance_i,
  output logic [$clog2(W)-1:0] col_o,
  output logic [$clog2(H)-1:0] row_o,
  output logic                 last_o
);

  localparam int CW = $clog2(W);
  localparam int RW = $clog2(H);
  localparam logic [CW-1:0] COL_LAST = CW'(W - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(H - 1);

  logic [CW-1:0] col_q, col_d;
  logic [RW-1:0] row_q, row_d;

  always_comb begin
    col_d = col_q;
    row_d = row_q;
    if (clear_i) begin
      col_d = '0;
      row_d = '0;
    end else if (advance_i) begin
      if (col_q == COL_LAST) begin
        col_d = '0;
        row_d = (row_q == ROW_LAST) ? '0 : row_q + 1'b1;
      end else begin
        col_d = col_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge nreset_i) begin
    if (!nreset_i) begin
      col_q <= '0;
      row_q <= '0;
    end else begin
      col_q <= col_d;
      row_q <= row_d;
    end
  end

  assign col_o  = col_q;
  assign row_o  = row_q;
  assign last_o = (col_q == COL_LAST) && (row_q == ROW_LAST);

endmodule

// File: rtl/sobel_frame_ctrl.sv
// Frame sequencer between the SPI pixel stream and the grayscale/Sobel datapath.
// Define SOBEL_FRAME_CTRL_BORDER_ZERO_EN to force frame-border output pixels to zero.
module sobel_frame_ctrl
  import gray_sobel_pkg::*;
#(
  parameter int IMG_W        = IMG_W_DEF,
  parameter int IMG_H        = IMG_H_DEF,
  parameter int MAX_INFLIGHT = 4,
  parameter int DRAIN_CYC    = 255
) (
  input  logic                   clk_i,
  input  logic                   nreset_i,
  input  logic                   frame_start_i,
  input  logic [1:0]             select_i,
  input  logic                   in_valid_i,
  input  logic [PIXEL_WIDTH-1:0] in_px_i,
  output logic                   dp_start_o,
  output logic [PIXEL_WIDTH-1:0] dp_px_o,
  output logic [1:0]             dp_select_o,
  input  logic                   dp_ready_i,
  input  logic [PIXEL_WIDTH-1:0] dp_px_i,
  output logic                   out_valid_o,
  output logic [PIXEL_WIDTH-1:0] out_px_o,
  output logic                   busy_o,
  output logic                   frame_done_o,
  output logic                   overflow_o,
  output logic                   timeout_o
);

  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);
  localparam int NW = $clog2(IMG_W * IMG_H + 1);
  localparam int IW = $clog2(MAX_INFLIGHT + 1);
  localparam int TW = $clog2(DRAIN_CYC + 1);
  localparam logic [NW-1:0] PX_TOTAL    = NW'(IMG_W * IMG_H);
  localparam logic [IW-1:0] INFL_MAX    = IW'(MAX_INFLIGHT);
  localparam logic [TW-1:0] DRAIN_LIMIT = TW'(DRAIN_CYC);

  frame_state_t           state_q;
  logic                   start_prev_q;
  logic [IW-1:0]          inflight_q;
  logic [NW-1:0]          returned_q;
  logic [TW-1:0]          timer_q;
  logic                   dp_start_q, out_valid_q, frame_done_q, overflow_q, timeout_q;
  logic [PIXEL_WIDTH-1:0] dp_px_q, out_px_q, out_px_d;
  logic [1:0]             dp_select_q;

  logic          start_edge, frame_arm, accept, drop, ret;
  logic [CW-1:0] in_col;
  logic [RW-1:0] in_row;
  logic          in_last;
  logic          unused_in_pos;

  assign start_edge = frame_start_i & ~start_prev_q;
  assign frame_arm  = (state_q == IDLE) && start_edge;
  assign accept     = (state_q == STREAM) && in_valid_i && (inflight_q < INFL_MAX);
  assign drop       = (state_q == STREAM) && in_valid_i && !(inflight_q < INFL_MAX);
  assign ret        = ((state_q == STREAM) || (state_q == DRAIN)) && dp_ready_i;

  raster_counter #(.W(IMG_W), .H(IMG_H)) u_in_raster (
    .clk_i     (clk_i),
    .nreset_i  (nreset_i),
    .clear_i   (frame_arm),
    .advance_i (accept),
    .col_o     (in_col),
    .row_o     (in_row),
    .last_o    (in_last)
  );

  assign unused_in_pos = ^{in_col, in_row};

`ifdef SOBEL_FRAME_CTRL_BORDER_ZERO_EN
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);

  logic [CW-1:0] out_col;
  logic [RW-1:0] out_row;
  logic          out_last, out_border, unused_out_last;

  // Output position only moves on returns that belong to the frame.
  raster_counter #(.W(IMG_W), .H(IMG_H)) u_out_raster (
    .clk_i     (clk_i),
    .nreset_i  (nreset_i),
    .clear_i   (frame_arm),
    .advance_i (ret),
    .col_o     (out_col),
    .row_o     (out_row),
    .last_o    (out_last)
  );

  assign unused_out_last = out_last;
  assign out_border = (out_col == '0) || (out_row == '0) ||
                      (out_col == COL_LAST) || (out_row == ROW_LAST);
  assign out_px_d   = out_border ? '0 : dp_px_i;
`else
  assign out_px_d = dp_px_i;
`endif

  always_ff @(posedge clk_i or negedge nreset_i) begin
    if (!nreset_i) begin
      state_q      <= IDLE;
      start_prev_q <= 1'b0;
      inflight_q   <= '0;
      returned_q   <= '0;
      timer_q      <= '0;
      dp_start_q   <= 1'b0;
      dp_px_q      <= '0;
      dp_select_q  <= '0;
      out_valid_q  <= 1'b0;
      out_px_q     <= '0;
      frame_done_q <= 1'b0;
      overflow_q   <= 1'b0;
      timeout_q    <= 1'b0;
    end else begin
      start_prev_q <= frame_start_i;
      dp_start_q   <= accept;
      out_valid_q  <= dp_ready_i;
      frame_done_q <= 1'b0;
      if (accept)     dp_px_q  <= in_px_i;
      if (dp_ready_i) out_px_q <= out_px_d;
      if (drop)       overflow_q <= 1'b1;

      // A same-cycle accept and return cancel out on the in-flight count.
      if (accept && !ret) begin
        inflight_q <= inflight_q + 1'b1;
      end else if (ret && !accept && (inflight_q != '0)) begin
        inflight_q <= inflight_q - 1'b1;
      end

      if (ret) begin
        returned_q <= returned_q + 1'b1;
        timer_q    <= '0;
      end

      case (state_q)
        IDLE: begin
          if (start_edge) begin
            dp_select_q <= select_i;
            inflight_q  <= '0;
            returned_q  <= '0;
            timer_q     <= '0;
            overflow_q  <= 1'b0;
            timeout_q   <= 1'b0;
            state_q     <= STREAM;
          end
        end
        STREAM: begin
          if (accept && in_last) state_q <= DRAIN;
        end
        DRAIN: begin
          if (returned_q == PX_TOTAL) begin
            frame_done_q <= 1'b1;
            state_q      <= DONE;
          end else if (!ret) begin
            if (timer_q == DRAIN_LIMIT) begin
              timeout_q    <= 1'b1;
              frame_done_q <= 1'b1;
              state_q      <= DONE;
            end else begin
              timer_q <= timer_q + 1'b1;
            end
          end
        end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign dp_start_o   = dp_start_q;
  assign dp_px_o      = dp_px_q;
  assign dp_select_o  = dp_select_q;
  assign out_valid_o  = out_valid_q;
  assign out_px_o     = out_px_q;
  assign busy_o       = (state_q != IDLE);
  assign frame_done_o = frame_done_q;
  assign overflow_o   = overflow_q;
  assign timeout_o    = timeout_q;

endmodule

// File: tb/tb_sobel_frame_ctrl.sv
// Bench for sobel_frame_ctrl on a 4x4 frame with two pixels in flight and a short drain limit.
module tb_sobel_frame_ctrl;
  import gray_sobel_pkg::*;

  localparam int W    = 4;
  localparam int H    = 4;
  localparam int MAXI = 2;
  localparam int DCYC = 20;

  logic       clk = 1'b0;
  logic       nreset = 1'b0;
  logic       frameStart = 1'b0;
  logic [1:0] selectIn = 2'b00;
  logic       inValid = 1'b0;
  logic [7:0] inPx = 8'h00;
  logic       dpStart;
  logic [7:0] dpPxOut;
  logic [1:0] dpSelect;
  logic       dpReady = 1'b0;
  logic [7:0] dpPxIn = 8'h00;
  logic       outValid;
  logic [7:0] outPx;
  logic       busy, frameDone, overflow, timeout;

  always #5 clk = ~clk;

  sobel_frame_ctrl #(.IMG_W(W), .IMG_H(H), .MAX_INFLIGHT(MAXI), .DRAIN_CYC(DCYC)) dut (
    .clk_i        (clk),
    .nreset_i     (nreset),
    .frame_start_i(frameStart),
    .select_i     (selectIn),
    .in_valid_i   (inValid),
    .in_px_i      (inPx),
    .dp_start_o   (dpStart),
    .dp_px_o      (dpPxOut),
    .dp_select_o  (dpSelect),
    .dp_ready_i   (dpReady),
    .dp_px_i      (dpPxIn),
    .out_valid_o  (outValid),
    .out_px_o     (outPx),
    .busy_o       (busy),
    .frame_done_o (frameDone),
    .overflow_o   (overflow),
    .timeout_o    (timeout)
  );

  typedef struct {
    logic [7:0] inPx;
    logic [7:0] retPx;
    logic [7:0] expOut;
  } vec_t;

  vec_t       frameTbl[16];
  logic [7:0] dpQ[$];
  logic [7:0] outQ[$];
  int         checks = 0;
  int         fails = 0;
  int         dpStarts = 0;
  int         outValids = 0;
  int         dones = 0;
  int         retIdx = 0;

  // Forwarded result for the idx-th returned pixel of a frame.
  function automatic logic [7:0] expOut(input int idx, input logic [7:0] px);
`ifdef SOBEL_FRAME_CTRL_BORDER_ZERO_EN
    if ((idx / W) == 0 || (idx % W) == 0 || (idx / W) == H - 1 || (idx % W) == W - 1)
      return 8'h00;
`endif
    return px;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Drive one cycle of inputs at a negedge; expectations enter the scoreboard here.
  task automatic applyStimulus(input logic v, input logic [7:0] px, input logic r,
                               input logic [7:0] rpx, input logic expAccept);
    inValid = v;
    inPx    = px;
    dpReady = r;
    dpPxIn  = rpx;
    if (v && expAccept) dpQ.push_back(px);
    if (r) begin
      outQ.push_back(expOut(retIdx, rpx));
      retIdx++;
    end
    @(posedge clk);
    @(negedge clk);
    inValid = 1'b0;
    dpReady = 1'b0;
  endtask

  task automatic startFrame(input logic [1:0] sel);
    frameStart = 1'b1;
    selectIn   = sel;
    @(posedge clk);
    @(negedge clk);
    frameStart = 1'b0;
    retIdx     = 0;
    checkOutput("start busy", busy, 1);
    checkOutput("start dp_select", dpSelect, sel);
  endtask

  // Scoreboard monitor: samples shortly after each active edge.
  always begin
    @(posedge clk);
    #1;
    if (nreset) begin
      if (dpStart) begin
        dpStarts++;
        if (dpQ.size() == 0) begin
          checks++;
          fails++;
          $display("[TB] FAIL dp_start: got strobe px 0x%0h, expected no strobe", dpPxOut);
        end else begin
          checkOutput("dp_px", dpPxOut, dpQ.pop_front());
        end
      end
      if (outValid) begin
        outValids++;
        if (outQ.size() == 0) begin
          checks++;
          fails++;
          $display("[TB] FAIL out_valid: got strobe px 0x%0h, expected no strobe", outPx);
        end else begin
          checkOutput("out_px", outPx, outQ.pop_front());
        end
      end
      if (frameDone) dones++;
    end
  end

  initial begin
    int n;
    int d0, o0, f0;

    for (int i = 0; i < 16; i++) begin
      frameTbl[i].inPx = 8'(i * 13 + 5);
`ifdef SOBEL_FRAME_CTRL_BORDER_ZERO_EN
      frameTbl[i].retPx = 8'hFF;
`else
      frameTbl[i].retPx = 8'(200 - i * 11);
`endif
      frameTbl[i].expOut = expOut(i, frameTbl[i].retPx);
    end

    repeat (2) @(negedge clk);
    checkOutput("reset busy", busy, 0);
    checkOutput("reset flags", {dpStart, outValid, frameDone, overflow, timeout}, 0);
    checkOutput("reset data", {dpSelect, dpPxOut, outPx}, 0);
    nreset = 1'b1;
    @(negedge clk);

    // Reset in the middle of a frame after five accepts.
    startFrame(2'b11);
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b1, 8'(8'h10 + i), 1'b0, 8'h00, 1'b1);
      applyStimulus(1'b0, 8'h00, 1'b1, 8'(8'h20 + i), 1'b0);
    end
    checkOutput("mid-frame col", dut.u_in_raster.col_q, 1);
    checkOutput("mid-frame row", dut.u_in_raster.row_q, 1);
    #2 nreset = 1'b0;
    #1;
    checkOutput("async reset busy", busy, 0);
    checkOutput("async reset flags", {dpStart, outValid, frameDone, overflow, timeout}, 0);
    checkOutput("async reset data", {dpSelect, dpPxOut, outPx}, 0);
    dpQ.delete();
    outQ.delete();
    @(negedge clk);
    nreset = 1'b1;
    @(negedge clk);

    // Full 4x4 frame, spaced pixels, each returned three cycles after it is sent.
    startFrame(2'b10);
    checkOutput("clean start col", dut.u_in_raster.col_q, 0);
    checkOutput("clean start row", dut.u_in_raster.row_q, 0);
    d0 = dpStarts;
    o0 = outValids;
    f0 = dones;
    for (int i = 0; i < 16; i++) begin
      if (i == 6) frameStart = 1'b1;
      if (i == 8) selectIn = 2'b01;
      if (i == 9) frameStart = 1'b0;
      applyStimulus(1'b1, frameTbl[i].inPx, 1'b0, 8'h00, 1'b1);
      applyStimulus(1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
      applyStimulus(1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
      applyStimulus(1'b0, 8'h00, 1'b1, frameTbl[i].retPx, 1'b0);
      checkOutput($sformatf("frame out_px %0d", i), outPx, frameTbl[i].expOut);
      checkOutput("dp_select frozen", dpSelect, 2'b10);
    end
    n = 0;
    while (!frameDone && n < 10) begin
      @(negedge clk);
      n++;
    end
    checkOutput("frame_done seen", frameDone, 1);
    @(negedge clk);
    checkOutput("idle after done", {busy, frameDone}, 0);
    checkOutput("frame dp_start count", dpStarts - d0, 16);
    checkOutput("frame out_valid count", outValids - o0, 16);
    checkOutput("frame done count", dones - f0, 1);
    checkOutput("frame no overflow", overflow, 0);
    checkOutput("frame no timeout", timeout, 0);

    // Overflow, same-cycle accept/return, then a drain that times out.
    startFrame(2'b01);
    d0 = dpStarts;
    f0 = dones;
    applyStimulus(1'b1, 8'hA0, 1'b0, 8'h00, 1'b1);
    checkOutput("first dp_start", {dpStart, dpPxOut}, {1'b1, 8'hA0});
    applyStimulus(1'b1, 8'hA1, 1'b0, 8'h00, 1'b1);
    applyStimulus(1'b1, 8'hA2, 1'b0, 8'h00, 1'b0);
    checkOutput("overflow set", overflow, 1);
    checkOutput("dropped no strobe", dpStart, 0);
    checkOutput("overflow col", dut.u_in_raster.col_q, 2);
    checkOutput("overflow inflight", dut.inflight_q, 2);
    checkOutput("overflow dp_start count", dpStarts - d0, 2);
    applyStimulus(1'b0, 8'h00, 1'b1, 8'h55, 1'b0);
    checkOutput("return inflight", dut.inflight_q, 1);
    applyStimulus(1'b1, 8'hA3, 1'b1, 8'h56, 1'b1);
    checkOutput("same-cycle inflight", dut.inflight_q, 1);
    checkOutput("same-cycle strobes", {dpStart, outValid}, 2'b11);
    checkOutput("same-cycle col", dut.u_in_raster.col_q, 3);
    for (int k = 0; k < 13; k++) begin
      applyStimulus(1'b1, 8'(8'hB0 + k), 1'b1, 8'(8'hC0 + k), 1'b1);
    end
    n = 0;
    while (!frameDone && n < DCYC + 10) begin
      @(posedge clk);
      n++;
      @(negedge clk);
    end
    checkOutput("drain timeout latency", n, DCYC + 1);
    checkOutput("timeout set", timeout, 1);
    checkOutput("overflow sticky", overflow, 1);
    @(negedge clk);
    @(negedge clk);
    checkOutput("timeout frame done count", dones - f0, 1);
    checkOutput("timeout sticky idle", {busy, timeout}, 2'b01);
    checkOutput("dp queue drained", dpQ.size(), 0);
    checkOutput("out queue drained", outQ.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
